// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues in-order imem requests and buffers responses
// in a prefetch FIFO for decode. Define FETCH_STATS_EN to enable the pop/redirect counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic [31:0] fetched_count,
    output logic [31:0] redirect_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CRD_W = CNT_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0] data_mem [FIFO_DEPTH];
    logic [31:0] pc_mem   [FIFO_DEPTH];

    logic [CRD_W-1:0] credit_used;
    logic [CRD_W-1:0] stale;
    logic [31:0]      redirect_target;
    logic             req_fire;
    logic             push;
    logic             pop;
    logic             unused_redirect_lsbs;

    assign redirect_target      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // In-flight requests plus buffered entries may never exceed the FIFO depth.
    assign credit_used    = {1'b0, inflight_q} + {1'b0, count_q};
    assign imem_req_valid = (state_q == S_FETCH) && !redirect_valid &&
                            (credit_used < CRD_W'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign push = imem_resp_valid && !redirect_valid && (discard_q == '0) && (inflight_q != '0);

    assign inst_valid = (count_q != '0);
    assign inst_data  = inst_valid ? data_mem[rd_ptr_q] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem[rd_ptr_q] : 32'h0;
    assign pop        = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;
        stale      = {1'b0, discard_q} + {1'b0, inflight_q};
        if (redirect_valid) begin
            pc_d       = redirect_target;
            resp_pc_d  = redirect_target;
            inflight_d = '0;
            // A response landing this cycle retires one of the stale requests.
            if (imem_resp_valid && (stale != '0)) begin
                stale = stale - CRD_W'(1);
            end
            discard_d = stale[CNT_W-1:0];
            state_d   = (stale != '0) ? S_DRAIN : S_FETCH;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (imem_resp_valid) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CNT_W'(1);
                end else if (inflight_q != '0) begin
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
            inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(push);
            case (state_q)
                S_IDLE:  state_d = S_FETCH;
                S_DRAIN: if (discard_d == '0) state_d = S_FETCH;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_valid) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            wr_ptr_d = wr_ptr_q + PTR_W'(push);
            rd_ptr_d = rd_ptr_q + PTR_W'(pop);
            count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_resp_data;
            pc_mem[wr_ptr_q]   <= resp_pc_q;
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_count_q;
    logic [31:0] redirect_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            fetched_count_q  <= 32'h0;
            redirect_count_q <= 32'h0;
        end else begin
            if (pop) begin
                fetched_count_q <= fetched_count_q + 32'd1;
            end
            if (redirect_valid) begin
                redirect_count_q <= redirect_count_q + 32'd1;
            end
        end
    end

    assign fetched_count  = fetched_count_q;
    assign redirect_count = redirect_count_q;
`else
    assign fetched_count  = 32'h0;
    assign redirect_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order memory model with random latency plus an
// address-stream scoreboard (expected PCs restart at each redirect target).
module tb_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
`ifdef FETCH_STATS_EN
    localparam logic [31:0] STATS_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] STATS_MASK = 32'h0;
`endif

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] fetched_count;
    logic [31:0] redirect_count;

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fetched_count  (fetched_count),
        .redirect_count (redirect_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    req_t        mq[$];
    logic [31:0] fire_log[$];
    logic [31:0] pop_log[$];
    int          total = 0;
    int          bad = 0;
    int          cyc;
    int          epoch;
    int          buffered;
    int          pops;
    int          redirects;
    int          lat;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    logic [31:0] hold_addr;
    bit          idle;
    bit          hold_pending;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int count_out(input bit current);
        int n = 0;
        foreach (mq[i]) begin
            if ((mq[i].epoch == epoch) == current) n++;
        end
        return n;
    endfunction

    function automatic logic [31:0] exp_stat(input int n);
        return 32'(n) & STATS_MASK;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        imem_req_ready  = 1'b1;
        inst_ready      = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_fetched", fetched_count, 32'h0);
        chk("rst_redirects", redirect_count, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        mq.delete();
        fire_log.delete();
        pop_log.delete();
        epoch++;
        buffered     = 0;
        pops         = 0;
        redirects    = 0;
        cyc          = 0;
        exp_pc       = RST_PC;
        exp_req      = RST_PC;
        idle         = 1'b1;
        hold_pending = 1'b0;
    endtask

    // One clock: memory drives its response, outputs are checked at the negedge, model updated.
    task automatic cycle();
        logic        rv, fire, pop, resp;
        logic [31:0] rp, addr;
        bit          exp_rv;
        int          c;
        req_t        head;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        @(negedge clock);
        rv     = redirect_valid;
        rp     = redirect_pc;
        c      = cyc;
        exp_rv = !idle && count_out(1'b0) == 0 && !rv && (count_out(1'b1) + buffered) < DEPTH;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
        if (imem_req_valid) chk("req_addr", imem_req_addr, exp_req);
        if (hold_pending && !rv) chk("req_hold", imem_req_addr, hold_addr);
        chk("inst_valid", 32'(inst_valid), 32'(buffered != 0));
        pop = inst_valid && inst_ready && !rv;
        if (pop) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_data", inst_data, mem_word(exp_pc));
            pop_log.push_back(inst_pc);
        end
        fire         = imem_req_valid && imem_req_ready;
        addr         = imem_req_addr;
        resp         = imem_resp_valid;
        hold_pending = imem_req_valid && !imem_req_ready && !rv;
        hold_addr    = addr;
        @(posedge clock);
        #1;
        cyc++;
        idle = 1'b0;
        if (resp) begin
            head = mq.pop_front();
            if (head.epoch == epoch && !rv) buffered++;
        end
        if (fire) begin
            mq.push_back('{addr: addr, due: c + lat, epoch: epoch});
            fire_log.push_back(addr);
            exp_req = exp_req + 32'd4;
        end
        if (pop) begin
            buffered--;
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (rv) begin
            epoch++;
            buffered     = 0;
            exp_pc       = {rp[31:2], 2'b00};
            exp_req      = exp_pc;
            redirects++;
            fire_log.delete();
            pop_log.delete();
            hold_pending = 1'b0;
        end
    endtask

    task automatic do_redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        int   n;
        int   p0;
        logic found;
        epoch = 0;
        lat   = 1;

        // Streaming at one instruction per cycle
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 1;
        repeat (10) cycle();
        n = pops;
        repeat (10) cycle();
        chk("t1_rate", 32'(pops - n), 32'd10);

        // Stalled decoder: credit limit stops requests at the FIFO depth
        do_reset();
        inst_ready = 1'b0;
        lat        = 1;
        repeat (10) cycle();
        chk("t2_reqs", 32'(fire_log.size()), 32'd4);
        chk("t2_req_valid", 32'(imem_req_valid), 32'h0);
        inst_ready = 1'b1;
        repeat (4) cycle();
        chk("t2_pops", 32'(pop_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk("t2_order", (pop_log.size() > i) ? pop_log[i] : 32'hx, 32'(4 * i));
        end

        // Three requests in flight when redirected
        do_reset();
        inst_ready = 1'b1;
        lat        = 4;
        for (int i = 0; i < 20 && mq.size() < 3; i++) cycle();
        chk("t3_inflight", 32'(mq.size()), 32'd3);
        do_redirect(32'h0000_0100);
        for (int i = 0; i < 30 && pop_log.size() == 0; i++) cycle();
        chk("t3_first_pc", (pop_log.size() > 0) ? pop_log[0] : 32'hx, 32'h0000_0100);

        // Redirect coinciding with a response and a pop
        do_reset();
        inst_ready = 1'b1;
        lat        = 2;
        repeat (8) cycle();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mq.size() > 0 && mq[0].due <= cyc && inst_valid) found = 1'b1;
            else cycle();
        end
        chk("t4_found", 32'(found), 32'h1);
        p0 = pops;
        do_redirect(32'h0000_0300);
        chk("t4_no_pop", fetched_count, exp_stat(p0));
        chk("t4_flush", 32'(inst_valid), 32'h0);
        for (int i = 0; i < 20 && fire_log.size() == 0; i++) cycle();
        chk("t4_next_addr", (fire_log.size() > 0) ? fire_log[0] : 32'hx, 32'h0000_0300);

        // Alignment of redirect targets and PC wrap
        do_redirect(32'h0000_0203);
        for (int i = 0; i < 20 && fire_log.size() == 0; i++) cycle();
        chk("t5_align", (fire_log.size() > 0) ? fire_log[0] : 32'hx, 32'h0000_0200);
        do_redirect(32'hFFFF_FFF8);
        for (int i = 0; i < 30 && fire_log.size() < 3; i++) cycle();
        chk("t5_wrap", (fire_log.size() > 2) ? fire_log[2] : 32'hx, 32'h0);
        for (int i = 0; i < 30 && pop_log.size() < 3; i++) cycle();
        chk("t5_wrap_pc", (pop_log.size() > 2) ? pop_log[2] : 32'hx, 32'h0);

        // Random traffic: ready, latency, decoder back-pressure and redirects
        for (int i = 0; i < 400; i++) begin
            imem_req_ready = ($urandom_range(0, 3) != 0);
            inst_ready     = ($urandom_range(0, 2) != 0);
            lat            = $urandom_range(1, 4);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = $urandom;
            cycle();
        end
        redirect_valid = 1'b0;
        chk("rand_fetched", fetched_count, exp_stat(pops));
        chk("rand_redirects", redirect_count, exp_stat(redirects));

        // Statistics: ten pops, two redirects
        do_reset();
        imem_req_ready = 1'b1;
        inst_ready     = 1'b1;
        lat            = 1;
        for (int i = 0; i < 40 && pops < 10; i++) cycle();
        inst_ready = 1'b0;
        do_redirect(32'h0000_0040);
        repeat (3) cycle();
        do_redirect(32'h0000_0080);
        repeat (3) cycle();
        chk("st_fetched", fetched_count, exp_stat(10));
        chk("st_redirects", redirect_count, exp_stat(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
